// File: rtl/mldsa_ahb_loader_if.sv
// mldsa_ahb_loader_if: AHB-lite bus bundle between the loader (master) and the mldsa slave port
interface mldsa_ahb_loader_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 64
);
    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic hsel_o;
    logic hwrite_o;
    logic [1:0] htrans_o;
    logic [2:0] hsize_o;
    logic hready_o;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;
    logic hreadyout_i;
    logic hresp_i;
    modport master (
        output haddr_o, hwdata_o, hsel_o, hwrite_o, htrans_o, hsize_o, hready_o,
        input  hrdata_i, hreadyout_i, hresp_i
    );
    modport slave (
        input  haddr_o, hwdata_o, hsel_o, hwrite_o, htrans_o, hsize_o, hready_o,
        output hrdata_i, hreadyout_i, hresp_i
    );
endinterface

// File: rtl/mldsa_ahb_loader.sv
// mldsa_ahb_loader: AHB-lite master that streams a word block, writes a command and polls STATUS
module mldsa_ahb_loader #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 64,
    parameter logic [AHB_ADDR_WIDTH-1:0] CTRL_ADDR = 'h10,
    parameter logic [AHB_ADDR_WIDTH-1:0] STATUS_ADDR = 'h18,
    parameter int STATUS_VALID_BIT = 1,
    parameter int CNT_W = 12,
    parameter int POLL_MAX = 1000
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start_i,
    input  logic [AHB_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_W-1:0] word_cnt_i,
    input  logic [31:0] cmd_i,
    input  logic data_valid_i,
    input  logic [31:0] data_i,
    output logic data_ready_o,
    output logic busy_o,
    output logic done_o,
    output logic error_o,
    output logic [CNT_W-1:0] words_written_o,
    mldsa_ahb_loader_if.master ahb
);
    localparam int PW = $clog2(POLL_MAX + 1);
    typedef enum logic [3:0] {
        IDLE, LD_WAIT, LD_ADDR, LD_DATA, CMD_ADDR, CMD_DATA, POLL_ADDR, POLL_DATA, DONE, ERR
    } state_t;
    state_t state, state_nxt;
    logic [AHB_ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0] cmd, word, wword, status;
    logic [PW-1:0] poll_cnt;
    logic is_addr, is_wdata, xfer_ok, last_word, status_valid, poll_exhausted;
    assign is_addr = state inside {LD_ADDR, CMD_ADDR, POLL_ADDR};
    assign is_wdata = state inside {LD_DATA, CMD_DATA};
    assign xfer_ok = ahb.hreadyout_i && !ahb.hresp_i;
    assign last_word = words_written_o + 1'b1 == word_cnt;
    assign status = STATUS_ADDR[2] ? ahb.hrdata_i[63:32] : ahb.hrdata_i[31:0];
    assign status_valid = status[STATUS_VALID_BIT];
    assign poll_exhausted = poll_cnt + 1'b1 == PW'(POLL_MAX);
    assign wword = state == CMD_DATA ? cmd : word;
    assign ahb.hsel_o = is_addr || is_wdata || state == POLL_DATA;
    assign ahb.htrans_o = is_addr ? 2'b10 : 2'b00;
    assign ahb.hwrite_o = state == LD_ADDR || state == CMD_ADDR;
    assign ahb.haddr_o = addr;
    assign ahb.hwdata_o = is_wdata ? (addr[2] ? {wword, 32'h0} : {32'h0, wword}) : '0;
    assign ahb.hsize_o = 3'b010;
    assign ahb.hready_o = ahb.hreadyout_i;
    assign data_ready_o = state == LD_WAIT;
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
    // State register
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else state <= state_nxt;
    // Next state; a data phase ends on the first ready cycle and an error response wins over everything
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start_i) state_nxt = word_cnt_i != '0 ? LD_WAIT : CMD_ADDR;
            LD_WAIT:   if (data_valid_i) state_nxt = LD_ADDR;
            LD_ADDR:   state_nxt = LD_DATA;
            LD_DATA:   if (ahb.hreadyout_i) state_nxt = ahb.hresp_i ? ERR : last_word ? CMD_ADDR : LD_WAIT;
            CMD_ADDR:  state_nxt = CMD_DATA;
            CMD_DATA:  if (ahb.hreadyout_i) state_nxt = ahb.hresp_i ? ERR : POLL_ADDR;
            POLL_ADDR: state_nxt = POLL_DATA;
            POLL_DATA: if (ahb.hreadyout_i)
                state_nxt = ahb.hresp_i ? ERR : status_valid ? DONE : poll_exhausted ? ERR : POLL_ADDR;
            DONE, ERR: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    // Job parameters, load word, address/word/poll counters and the sticky error flag
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            addr <= '0;
            word_cnt <= '0;
            cmd <= '0;
            word <= '0;
            words_written_o <= '0;
            poll_cnt <= '0;
            error_o <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                addr <= word_cnt_i != '0 ? base_addr_i : CTRL_ADDR;
                word_cnt <= word_cnt_i;
                cmd <= cmd_i;
                words_written_o <= '0;
                poll_cnt <= '0;
                error_o <= 1'b0;
            end
            if (state == LD_WAIT && data_valid_i) word <= data_i;
            if (state == LD_DATA && xfer_ok) begin
                words_written_o <= words_written_o + 1'b1;
                addr <= last_word ? CTRL_ADDR : addr + AHB_ADDR_WIDTH'(4);
            end
            if (state == CMD_DATA && xfer_ok) addr <= STATUS_ADDR;
            if (state == POLL_DATA && xfer_ok && !status_valid) poll_cnt <= poll_cnt + 1'b1;
            if (state_nxt == ERR) error_o <= 1'b1;
        end
endmodule

// File: tb/tb_mldsa_ahb_loader.sv
// tb_mldsa_ahb_loader: directed bench with an AHB slave model and an expected-transfer scoreboard
module tb_mldsa_ahb_loader;
    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    logic start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [11:0] word_cnt_i = '0;
    logic [31:0] cmd_i = '0;
    logic data_valid_i, data_ready_o, busy_o, done_o, error_o;
    logic [31:0] data_i;
    logic [11:0] words_written_o;
    mldsa_ahb_loader_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64)) ahb ();
    mldsa_ahb_loader dut (
        .clk(clk), .rst_b(rst_b), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_cnt_i(word_cnt_i), .cmd_i(cmd_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .data_ready_o(data_ready_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .words_written_o(words_written_o), .ahb(ahb)
    );
    logic start2 = 1'b0;
    logic ready2, busy2, done2, error2;
    logic [11:0] ww2;
    mldsa_ahb_loader_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(64)) ahb2 ();
    assign ahb2.hreadyout_i = 1'b1;
    assign ahb2.hresp_i = 1'b0;
    assign ahb2.hrdata_i = 64'h0;
    mldsa_ahb_loader #(.POLL_MAX(3)) dut2 (
        .clk(clk), .rst_b(rst_b), .start_i(start2), .base_addr_i(32'h0),
        .word_cnt_i(12'h0), .cmd_i(32'h5), .data_valid_i(1'b0), .data_i(32'h0),
        .data_ready_o(ready2), .busy_o(busy2), .done_o(done2), .error_o(error2),
        .words_written_o(ww2), .ahb(ahb2)
    );
    typedef struct packed {
        logic [31:0] a;
        logic w;
        logic [63:0] d;
    } xfer_t;
    xfer_t expq[$];
    xfer_t cur;
    logic [31:0] srcq[$];
    logic [63:0] logd[$];
    logic [31:0] loga[$];
    int wait_cyc, err_at, status_on, nxfer, nreads, ndone, wcnt, cyc;
    int nreads2, ndone2;
    bit toggle_valid, dphase;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Slave model, load-data source and per-cycle bus checks, all sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_b) begin
            dphase = 1'b0;
            ahb.hreadyout_i = 1'b1;
            ahb.hresp_i = 1'b0;
            ahb.hrdata_i = '0;
            data_valid_i = 1'b0;
            data_i = '0;
        end else begin
            cyc++;
            chk("hsize", ahb.hsize_o, 3'b010);
            chk("hready", ahb.hready_o, ahb.hreadyout_i);
            if (done_o) ndone++;
            if (dphase) begin
                chk("data_bus", {ahb.hsel_o, ahb.htrans_o}, 3'b100);
                if (cur.w) chk("hwdata", ahb.hwdata_o, cur.d);
                if (wcnt == 0) begin
                    nxfer++;
                    logd.push_back(ahb.hwdata_o);
                    ahb.hreadyout_i = 1'b1;
                    ahb.hresp_i = nxfer == err_at;
                    if (!cur.w) begin
                        nreads++;
                        ahb.hrdata_i = nreads == status_on ? 64'hFFFFFFFD_00000002 : 64'h00000002_00000000;
                    end
                    dphase = 1'b0;
                end else begin
                    ahb.hreadyout_i = 1'b0;
                    wcnt--;
                end
            end else begin
                ahb.hreadyout_i = 1'b1;
                ahb.hresp_i = 1'b0;
                if (ahb.htrans_o == 2'b10) begin
                    chk("addr_hsel", ahb.hsel_o, 1'b1);
                    loga.push_back(ahb.haddr_o);
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_xfer: got addr %0h want no transfer", ahb.haddr_o);
                        cur = '{a: ahb.haddr_o, w: 1'b0, d: 64'h0};
                    end else begin
                        cur = expq.pop_front();
                        chk("haddr", ahb.haddr_o, cur.a);
                        chk("hwrite", ahb.hwrite_o, cur.w);
                    end
                    dphase = 1'b1;
                    wcnt = wait_cyc;
                end else chk("idle_bus", {ahb.hsel_o, ahb.htrans_o}, 3'b000);
            end
            data_valid_i = srcq.size() != 0 && (!toggle_valid || cyc[0]);
            data_i = srcq.size() != 0 ? srcq[0] : 32'h0;
            if (data_valid_i && data_ready_o) void'(srcq.pop_front());
        end
    end

    // Read and done counter for the short-timeout instance
    always @(negedge clk) begin
        if (rst_b && ahb2.htrans_o == 2'b10 && !ahb2.hwrite_o) nreads2++;
        if (rst_b && done2) ndone2++;
    end

    task automatic start_run(input logic [31:0] base, input int cnt, input logic [31:0] cmd, input int polls,
                             input int eat, input int st_on, input int ws, input bit tog);
        logic [31:0] a, wd;
        expq.delete();
        srcq.delete();
        logd.delete();
        loga.delete();
        nxfer = 0;
        nreads = 0;
        ndone = 0;
        err_at = eat;
        status_on = st_on;
        wait_cyc = ws;
        toggle_valid = tog;
        for (int i = 0; i < cnt; i++) begin
            a = base + 32'(4 * i);
            wd = 32'h11 * 32'(i + 1);
            srcq.push_back(wd);
            expq.push_back('{a: a, w: 1'b1, d: a[2] ? {wd, 32'h0} : {32'h0, wd}});
        end
        expq.push_back('{a: 32'h10, w: 1'b1, d: {32'h0, cmd}});
        for (int i = 0; i < polls; i++) expq.push_back('{a: 32'h18, w: 1'b0, d: 64'h0});
        if (eat > 0) while (expq.size() > eat) void'(expq.pop_back());
        base_addr_i = base;
        word_cnt_i = 12'(cnt);
        cmd_i = cmd;
        start_i = 1'b1;
        @(negedge clk);
        #1;
        start_i = 1'b0;
        chk("start_busy", busy_o, 1'b1);
        chk("start_err_clear", error_o, 1'b0);
        chk("start_ww_clear", words_written_o, 12'h0);
    endtask

    task automatic finish_run(input string nm, input int exp_done, input int exp_ww, input bit exp_err, input int exp_reads);
        int k;
        for (k = 0; k < 5000 && busy_o; k++) begin
            @(negedge clk);
            #1;
        end
        if (busy_o) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy_o=1 after %0d cycles want 0", nm, k);
        end
        chk({nm, "_done"}, 64'(ndone), 64'(exp_done));
        chk({nm, "_ww"}, words_written_o, 64'(exp_ww));
        chk({nm, "_err"}, error_o, exp_err);
        chk({nm, "_reads"}, 64'(nreads), 64'(exp_reads));
        chk({nm, "_pending"}, 64'(expq.size()), 64'h0);
        srcq.delete();
    endtask

    initial begin
        #2 rst_b = 1'b0;
        #1;
        chk("rst_hsel", ahb.hsel_o, 1'b0);
        chk("rst_htrans", ahb.htrans_o, 2'b00);
        chk("rst_hwrite", ahb.hwrite_o, 1'b0);
        chk("rst_haddr", ahb.haddr_o, 32'h0);
        chk("rst_hwdata", ahb.hwdata_o, 64'h0);
        chk("rst_hsize", ahb.hsize_o, 3'b010);
        chk("rst_flags", {data_ready_o, busy_o, done_o, error_o}, 4'b0000);
        chk("rst_ww", words_written_o, 12'h0);
        repeat (2) @(negedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        #1;
        start_run(32'h4000, 4, 32'h2, 1, 0, 1, 0, 1'b0);
        finish_run("t1", 1, 4, 1'b0, 1);
        chk("t1_d0", logd[0], 64'h00000000_00000011);
        chk("t1_d1", logd[1], 64'h00000022_00000000);
        chk("t1_d2", logd[2], 64'h00000000_00000033);
        chk("t1_d3", logd[3], 64'h00000044_00000000);
        chk("t1_cmd", logd[4], 64'h00000000_00000002);
        chk("t1_a3", loga[3], 32'h400C);
        chk("t1_poll_addr", loga[5], 32'h18);
        start_run(32'h4000, 0, 32'h1, 1, 0, 1, 0, 1'b0);
        finish_run("t2", 1, 0, 1'b0, 1);
        chk("t2_first_addr", loga[0], 32'h10);
        chk("t2_nxfer", 64'(loga.size()), 64'd2);
        start_run(32'h1004, 5, 32'h3, 2, 0, 2, 3, 1'b1);
        finish_run("t3", 1, 5, 1'b0, 2);
        chk("t3_d0", logd[0], 64'h00000011_00000000);
        start_run(32'h0, 0, 32'h7, 5, 0, 5, 0, 1'b0);
        finish_run("t4", 1, 0, 1'b0, 5);
        start_run(32'h4000, 4, 32'h2, 0, 2, 0, 0, 1'b0);
        finish_run("t5", 0, 1, 1'b1, 0);
        chk("t5_no_ctrl", 64'(loga.size()), 64'd2);
        repeat (5) @(negedge clk);
        #1;
        chk("t5_err_sticky", error_o, 1'b1);
        start_run(32'hFFFF_FFF8, 3, 32'h9, 1, 0, 1, 1, 1'b0);
        finish_run("t6", 1, 3, 1'b0, 1);
        chk("t6_wrap", loga[2], 32'h0);
        start_run(32'h4000, 4, 32'h2, 1, 0, 1, 3, 1'b0);
        for (int k = 0; k < 200 && !(dphase && loga.size() == 2); k++) begin
            @(negedge clk);
            #1;
        end
        chk("t7_reached_load", 64'(loga.size()), 64'd2);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("t7_rst_bus", {ahb.hsel_o, ahb.htrans_o, ahb.hwrite_o}, 4'b0000);
        chk("t7_rst_haddr", ahb.haddr_o, 32'h0);
        chk("t7_rst_hwdata", ahb.hwdata_o, 64'h0);
        chk("t7_rst_flags", {data_ready_o, busy_o, done_o, error_o}, 4'b0000);
        chk("t7_rst_ww", words_written_o, 12'h0);
        @(negedge clk);
        expq.delete();
        srcq.delete();
        #1 rst_b = 1'b1;
        @(negedge clk);
        #1;
        start_run(32'h4000, 2, 32'h4, 1, 0, 1, 0, 1'b0);
        finish_run("t7", 1, 2, 1'b0, 1);
        nreads2 = 0;
        ndone2 = 0;
        start2 = 1'b1;
        @(negedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k < 100 && busy2; k++) begin
            @(negedge clk);
            #1;
        end
        chk("t8_busy", busy2, 1'b0);
        chk("t8_reads", 64'(nreads2), 64'd3);
        chk("t8_err", error2, 1'b1);
        chk("t8_done", 64'(ndone2), 64'd0);
        chk("t8_ww", {ww2, ready2}, 13'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
